memtile_access_sched: RTL and testbench

//  Frame scheduler in front of memory_core in tile mode (mode=3). Admits up to cfg_depth

---
 rtl/memtile_access_sched.sv | 209 ++++++++++++++++++++
 tb/tb_memtile_access_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memtile_access_sched.sv
`default_nettype none
// ============================================================================
// Module   : memtile_access_sched
// Purpose  : Tile-mode frame scheduler: linear write fill, strided read drain.
//            Optional MEMTILE_SCHED_STREAM_EN lets reads overlap the fill.
// Revision : 1.0 - initial release
// ============================================================================
module memtile_access_sched #(
    parameter int AW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] cfg_depth,
    input  logic [CW-1:0] cfg_frames,
    input  logic [AW-1:0] cfg_start_addr,
    input  logic [1:0]    cfg_dim,
    input  logic [AW-1:0] cfg_stride_0,
    input  logic [AW-1:0] cfg_stride_1,
    input  logic [AW-1:0] cfg_stride_2,
    input  logic [CW-1:0] cfg_range_0,
    input  logic [CW-1:0] cfg_range_1,
    input  logic [CW-1:0] cfg_range_2,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wen,
    output logic [AW-1:0] wr_addr,
    input  logic          out_ready,
    output logic          ren,
    output logic [AW-1:0] rd_addr,
    output logic          busy,
    output logic          frame_done,
    output logic          done
);

    localparam int MW = (AW > CW) ? AW : CW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] depth_q, depth_d;
    logic [CW-1:0] frames_left_q, frames_left_d;
    logic [AW-1:0] base_q, base_d;
    logic [1:0]    dim_q, dim_d;
    logic [AW-1:0] stride0_q, stride0_d, stride1_q, stride1_d, stride2_q, stride2_d;
    logic [CW-1:0] range0_q, range0_d, range1_q, range1_d, range2_q, range2_d;
    logic [CW-1:0] count_wen_q, count_wen_d;
    logic [CW-1:0] count_ren_q, count_ren_d;
    logic [CW-1:0] idx0_q, idx0_d, idx1_q, idx1_d, idx2_q, idx2_d;

    logic [AW-1:0] rd_addr_raw;
    logic          carry0, carry1, carry2;
    logic          frame_end;

    assign rd_addr_raw = base_q + AW'(idx0_q) * stride0_q
                                + AW'(idx1_q) * stride1_q
                                + AW'(idx2_q) * stride2_q;
    assign carry0 = (idx0_q == range0_q - CW'(1));
    assign carry1 = (idx1_q == range1_q - CW'(1));
    assign carry2 = (idx2_q == range2_q - CW'(1));

    // Both counters sit at depth for exactly one cycle: the frame-boundary cycle.
    assign frame_end = ((state_q == ST_FILL) || (state_q == ST_DRAIN)) &&
                       (count_wen_q == depth_q) && (count_ren_q == depth_q);

    assign busy    = (state_q != ST_IDLE);
    assign wr_addr = AW'(count_wen_q);
    assign rd_addr = busy ? rd_addr_raw : '0;

    always_comb begin
        state_d       = state_q;
        depth_d       = depth_q;
        frames_left_d = frames_left_q;
        base_d        = base_q;
        dim_d         = dim_q;
        stride0_d     = stride0_q;
        stride1_d     = stride1_q;
        stride2_d     = stride2_q;
        range0_d      = range0_q;
        range1_d      = range1_q;
        range2_d      = range2_q;
        count_wen_d   = count_wen_q;
        count_ren_d   = count_ren_q;
        idx0_d        = idx0_q;
        idx1_d        = idx1_q;
        idx2_d        = idx2_q;
        in_ready      = 1'b0;
        wen           = 1'b0;
        ren           = 1'b0;
        frame_done    = 1'b0;
        done          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (cfg_depth != '0)) begin
                    depth_d       = cfg_depth;
                    frames_left_d = (cfg_frames == '0) ? CW'(1) : cfg_frames;
                    base_d        = cfg_start_addr;
                    dim_d         = (cfg_dim == 2'd0) ? 2'd1 : cfg_dim;
                    stride0_d     = cfg_stride_0;
                    stride1_d     = cfg_stride_1;
                    stride2_d     = cfg_stride_2;
                    range0_d      = (cfg_range_0 == '0) ? CW'(1) : cfg_range_0;
                    range1_d      = (cfg_range_1 == '0) ? CW'(1) : cfg_range_1;
                    range2_d      = (cfg_range_2 == '0) ? CW'(1) : cfg_range_2;
                    count_wen_d   = '0;
                    count_ren_d   = '0;
                    idx0_d        = '0;
                    idx1_d        = '0;
                    idx2_d        = '0;
                    state_d       = ST_FILL;
                end
            end
            ST_FILL: begin
                in_ready = (count_wen_q < depth_q);
                wen      = in_valid && in_ready;
`ifdef MEMTILE_SCHED_STREAM_EN
                ren      = out_ready && (count_ren_q < depth_q) &&
                           (MW'(rd_addr_raw) < MW'(count_wen_q));
`else
                ren      = 1'b0;
`endif
            end
            ST_DRAIN: begin
                ren = out_ready && (count_ren_q < depth_q);
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wen) begin
            count_wen_d = count_wen_q + CW'(1);
        end

        // Odometer: inner dim steps every read, outer dims step on inner wrap.
        if (ren) begin
            count_ren_d = count_ren_q + CW'(1);
            idx0_d      = carry0 ? '0 : idx0_q + CW'(1);
            if ((dim_q >= 2'd2) && carry0) begin
                idx1_d = carry1 ? '0 : idx1_q + CW'(1);
            end
            if ((dim_q == 2'd3) && carry0 && carry1) begin
                idx2_d = carry2 ? '0 : idx2_q + CW'(1);
            end
        end

        if (frame_end) begin
            frame_done    = 1'b1;
            count_wen_d   = '0;
            count_ren_d   = '0;
            idx0_d        = '0;
            idx1_d        = '0;
            idx2_d        = '0;
            frames_left_d = frames_left_q - CW'(1);
            state_d       = (frames_left_q > CW'(1)) ? ST_FILL : ST_DONE;
        end else if ((state_q == ST_FILL) && (count_wen_d == depth_q)) begin
            state_d = ST_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            depth_q       <= '0;
            frames_left_q <= '0;
            base_q        <= '0;
            dim_q         <= 2'd1;
            stride0_q     <= '0;
            stride1_q     <= '0;
            stride2_q     <= '0;
            range0_q      <= CW'(1);
            range1_q      <= CW'(1);
            range2_q      <= CW'(1);
            count_wen_q   <= '0;
            count_ren_q   <= '0;
            idx0_q        <= '0;
            idx1_q        <= '0;
            idx2_q        <= '0;
        end else begin
            state_q       <= state_d;
            depth_q       <= depth_d;
            frames_left_q <= frames_left_d;
            base_q        <= base_d;
            dim_q         <= dim_d;
            stride0_q     <= stride0_d;
            stride1_q     <= stride1_d;
            stride2_q     <= stride2_d;
            range0_q      <= range0_d;
            range1_q      <= range1_d;
            range2_q      <= range2_d;
            count_wen_q   <= count_wen_d;
            count_ren_q   <= count_ren_d;
            idx0_q        <= idx0_d;
            idx1_q        <= idx1_d;
            idx2_q        <= idx2_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memtile_access_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_memtile_access_sched
// Purpose  : Directed self-checking bench for memtile_access_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memtile_access_sched;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] cfg_depth, cfg_frames, cfg_start_addr;
    logic [1:0]  cfg_dim;
    logic [15:0] cfg_stride_0, cfg_stride_1, cfg_stride_2;
    logic [15:0] cfg_range_0, cfg_range_1, cfg_range_2;
    logic        in_valid, in_ready, wen, out_ready, ren, busy, frame_done, done;
    logic [15:0] wr_addr, rd_addr;

    int tests_run    = 0;
    int tests_failed = 0;

    memtile_access_sched #(.AW(16), .CW(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_depth(cfg_depth), .cfg_frames(cfg_frames), .cfg_start_addr(cfg_start_addr),
        .cfg_dim(cfg_dim),
        .cfg_stride_0(cfg_stride_0), .cfg_stride_1(cfg_stride_1), .cfg_stride_2(cfg_stride_2),
        .cfg_range_0(cfg_range_0), .cfg_range_1(cfg_range_1), .cfg_range_2(cfg_range_2),
        .in_valid(in_valid), .in_ready(in_ready), .wen(wen), .wr_addr(wr_addr),
        .out_ready(out_ready), .ren(ren), .rd_addr(rd_addr),
        .busy(busy), .frame_done(frame_done), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic set_cfg(input int depth, input int frames, input int base, input int dim,
                           input int s0, input int s1, input int s2,
                           input int r0, input int r1, input int r2);
        start          = 1'b0;
        cfg_depth      = 16'(depth);
        cfg_frames     = 16'(frames);
        cfg_start_addr = 16'(base);
        cfg_dim        = 2'(dim);
        cfg_stride_0   = 16'(s0);
        cfg_stride_1   = 16'(s1);
        cfg_stride_2   = 16'(s2);
        cfg_range_0    = 16'(r0);
        cfg_range_1    = 16'(r1);
        cfg_range_2    = 16'(r2);
    endtask

    task automatic test_reset();
        logic [5:0] got;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; #1;
        got = {busy, in_ready, wen, ren, frame_done, done};
        tests_run++;
        if (got !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected %b", got, 6'b0);
        end
        tests_run++;
        if ({wr_addr, rd_addr} !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_addr: got wr=%h rd=%h expected 0/0", wr_addr, rd_addr);
        end
    endtask

    // depth 4, one frame, linear read, no backpressure
    task automatic test_basic(input string tag);
        logic [4:0] exp, got;
        set_cfg(4, 1, 0, 1, 1, 0, 0, 4, 1, 1);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            start = (t == 0);
            #1;
            exp = {(t >= 1 && t <= 10), (t >= 1 && t <= 4), (t >= 5 && t <= 8), (t == 9), (t == 10)};
            got = {busy, wen, ren, frame_done, done};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s_ctrl t=%0d: got %b expected %b", tag, t, got, exp);
            end
            if (exp[3]) begin
                tests_run++;
                if (wr_addr !== 16'(t - 1)) begin
                    tests_failed++;
                    $display("FAIL %s_wr_addr t=%0d: got %0d expected %0d", tag, t, wr_addr, t - 1);
                end
            end
            if (exp[2]) begin
                tests_run++;
                if (rd_addr !== 16'(t - 5)) begin
                    tests_failed++;
                    $display("FAIL %s_rd_addr t=%0d: got %0d expected %0d", tag, t, rd_addr, t - 5);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_iterator();
        int exp_a [9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
        int nreads, exp, want;
        bit seen_done;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) set_cfg(9, 1, 0, 2, 3, 1, 0, 3, 3, 1);
            else        set_cfg(27, 1, 0, 3, 1, 3, 9, 3, 3, 3);
            want = (c == 0) ? 9 : 27;
            in_valid = 1'b1; out_ready = 1'b1;
            nreads = 0; seen_done = 1'b0;
            @(posedge clk); #1; start = 1'b1;
            for (int t = 0; t < 120 && !seen_done; t++) begin
                @(posedge clk); #1; start = 1'b0; #1;
                if (ren) begin
                    exp = (c == 0) ? ((nreads < 9) ? exp_a[nreads] : -1) : nreads;
                    tests_run++;
                    if (rd_addr !== 16'(exp)) begin
                        tests_failed++;
                        $display("FAIL iter%0d_rd_addr n=%0d: got %0d expected %0d", c, nreads, rd_addr, exp);
                    end
                    nreads++;
                end
                if (done) seen_done = 1'b1;
            end
            tests_run++;
            if (nreads != want || !seen_done) begin
                tests_failed++;
                $display("FAIL iter%0d_count: got %0d reads done=%0d expected %0d reads done=1",
                         c, nreads, seen_done, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // in_valid alternates; out_ready low t10..t12
    task automatic test_backpressure();
        logic [4:0] exp, got;
        int exp_rd;
        set_cfg(4, 1, 0, 1, 1, 0, 0, 4, 1, 1);
        for (int t = 0; t < 18; t++) begin
            @(posedge clk); #1;
            start     = (t == 0);
            in_valid  = (t % 2 == 1);
            out_ready = !(t >= 10 && t <= 12);
            #1;
            exp = {(t >= 1 && t <= 16), (t == 1 || t == 3 || t == 5 || t == 7),
                   (t == 8 || t == 9 || t == 13 || t == 14), (t == 15), (t == 16)};
            got = {busy, wen, ren, frame_done, done};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL bp_ctrl t=%0d: got %b expected %b", t, got, exp);
            end
            if (exp[3]) begin
                tests_run++;
                if (wr_addr !== 16'((t - 1) / 2)) begin
                    tests_failed++;
                    $display("FAIL bp_wr_addr t=%0d: got %0d expected %0d", t, wr_addr, (t - 1) / 2);
                end
            end
            if (t >= 8 && t <= 14) begin
                exp_rd = (t == 8) ? 0 : (t == 9) ? 1 : (t == 14) ? 3 : 2;
                tests_run++;
                if (rd_addr !== 16'(exp_rd)) begin
                    tests_failed++;
                    $display("FAIL bp_rd_addr t=%0d: got %0d expected %0d", t, rd_addr, exp_rd);
                end
            end
        end
        start = 1'b0;
    endtask

    // two frames of depth 3, base 0x100; stray start and cfg edits mid-run
    task automatic test_frames();
        logic [4:0] exp, got;
        int exp_wr, exp_rd;
        set_cfg(3, 2, 16'h0100, 1, 1, 0, 0, 3, 1, 1);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 17; t++) begin
            @(posedge clk); #1;
            start = (t == 0 || t == 5);
            if (t == 1) begin cfg_depth = 16'd5; cfg_frames = 16'd7; end
            #1;
            exp = {(t >= 1 && t <= 15), ((t >= 1 && t <= 3) || (t >= 8 && t <= 10)),
                   ((t >= 4 && t <= 6) || (t >= 11 && t <= 13)), (t == 7 || t == 14), (t == 15)};
            got = {busy, wen, ren, frame_done, done};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL frames_ctrl t=%0d: got %b expected %b", t, got, exp);
            end
            exp_wr = (t <= 3) ? t - 1 : t - 8;
            exp_rd = (t <= 6) ? 16'h0100 + t - 4 : 16'h0100 + t - 11;
            if (exp[3]) begin
                tests_run++;
                if (wr_addr !== 16'(exp_wr)) begin
                    tests_failed++;
                    $display("FAIL frames_wr_addr t=%0d: got %0d expected %0d", t, wr_addr, exp_wr);
                end
            end
            if (exp[2]) begin
                tests_run++;
                if (rd_addr !== 16'(exp_rd)) begin
                    tests_failed++;
                    $display("FAIL frames_rd_addr t=%0d: got %h expected %h", t, rd_addr, exp_rd);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [5:0] got;
        set_cfg(4, 1, 0, 1, 1, 0, 0, 4, 1, 1);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            start = (t == 0);
            reset = (t == 7);
            #1;
        end
        tests_run++;
        if ({ren, rd_addr} !== {1'b1, 16'd2}) begin
            tests_failed++;
            $display("FAIL rstmid_pre: got ren=%b rd=%0d expected ren=1 rd=2", ren, rd_addr);
        end
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            #1;
            got = {busy, in_ready, wen, ren, frame_done, done};
            tests_run++;
            if (got !== 6'b0) begin
                tests_failed++;
                $display("FAIL rstmid_idle c=%0d: got %b expected %b", t, got, 6'b0);
            end
        end
        test_basic("rerun");
        cfg_depth = 16'd0;
        @(posedge clk); #1; start = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1; start = 1'b0; #1;
            tests_run++;
            if ({busy, in_ready, wen} !== 3'b0) begin
                tests_failed++;
                $display("FAIL depth0_idle c=%0d: got %b expected 000", t, {busy, in_ready, wen});
            end
        end
    endtask

    task automatic test_stream();
        logic [4:0] exp, got;
        int wcount = 0;
        set_cfg(4, 1, 0, 1, 1, 0, 0, 4, 1, 1);
        out_ready = 1'b1;
        for (int t = 0; t < 15; t++) begin
            @(posedge clk); #1;
            start    = (t == 0);
            in_valid = (t % 2 == 1);
            #1;
`ifdef MEMTILE_SCHED_STREAM_EN
            exp = {(t >= 1 && t <= 10), (t == 1 || t == 3 || t == 5 || t == 7),
                   (t == 2 || t == 4 || t == 6 || t == 8), (t == 9), (t == 10)};
`else
            exp = {(t >= 1 && t <= 13), (t == 1 || t == 3 || t == 5 || t == 7),
                   (t >= 8 && t <= 11), (t == 12), (t == 13)};
`endif
            got = {busy, wen, ren, frame_done, done};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL stream_ctrl t=%0d: got %b expected %b", t, got, exp);
            end
            if (ren) begin
                tests_run++;
                if (!(rd_addr < 16'(wcount))) begin
                    tests_failed++;
                    $display("FAIL stream_order t=%0d: rd_addr %0d not below writes %0d", t, rd_addr, wcount);
                end
            end
            if (wen) wcount++;
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_iterator();
        test_backpressure();
        test_frames();
        test_reset_mid();
        test_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
